alu_seq: RTL
============

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The module SHALL have parameter NBYTES, default 4, giving the operand width in bytes (2 to 8).
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port req_valid, input, 1 bit: request present.
REQ-005 Port req_ready, output, 1 bit: the sequencer accepts the request this cycle.
REQ-006 Port req_op, input, 2 bits: 00 XOR, 01 AND, 10 SHL, 11 SHR.
REQ-007 Ports req_a and req_b, inputs, 8*NBYTES bits each: the operands.
REQ-008 Port req_ci, input, 1 bit: shift carry-in, used by SHL and SHR only.
REQ-009 Port rsp_valid, output, 1 bit: a result is held.
REQ-010 Port rsp_ready, input, 1 bit: the consumer takes the result.
REQ-011 Port rsp_data, output, 8*NBYTES bits: the result.
REQ-012 Port rsp_co, output, 1 bit: shift carry-out.
REQ-013 Port rsp_zero, output, 1 bit: zero flag (see Configuration).
REQ-014 Ports alu_cmd (output, 3 bits), alu_inA (output, 8 bits), alu_inB (output, 8 bits), alu_sc_i (output, 1 bit), alu_typeselect (output, 2 bits) and alu_immed (output, 4 bits) SHALL drive the combinational 8-bit ALU.
REQ-015 Ports alu_rslt (input, 8 bits) and alu_sc_o (input, 1 bit) SHALL return the ALU outputs.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-017 req_ready SHALL be 1 only in IDLE.
REQ-018 When req_valid and req_ready are both 1, the FSM SHALL register the operands, op and carry-in, clear the byte counter to 0 and enter RUN.
REQ-019 RUN SHALL last exactly NBYTES cycles, processing one byte per cycle; the counter SHALL advance by 1 each cycle.
REQ-020 Byte order SHALL be index k=cnt for XOR, AND and SHL, and k=NBYTES-1-cnt for SHR (MSB first).
REQ-021 In RUN, alu_inA SHALL be A byte k and alu_inB SHALL be B byte k.
REQ-022 The alu_cmd mapping SHALL be: XOR 011; AND 101; SHL 001 with alu_typeselect 11; SHR 001 with alu_typeselect 01.
REQ-023 alu_immed SHALL always be 0.
REQ-024 alu_sc_i SHALL equal the registered req_ci on the first RUN cycle, and the carry latched from alu_sc_o in the previous cycle thereafter.
REQ-025 alu_rslt SHALL be written into result byte k at the end of each RUN cycle.
REQ-026 When the last byte completes, the FSM SHALL enter DONE, and rsp_co SHALL equal the last latched carry for shifts and 0 for XOR and AND.
REQ-027 In DONE, rsp_valid SHALL be 1, and rsp_data, rsp_co and rsp_zero SHALL stay stable until rsp_ready is 1.
REQ-028 On DONE with rsp_ready=1, the FSM SHALL return to IDLE, clearing rsp_valid on the next edge.
REQ-029 Latency SHALL be NBYTES+1 cycles from the accept edge to rsp_valid.
REQ-030 Throughput SHALL be one operation per NBYTES+2 cycles when rsp_ready is held at 1.
REQ-031 A new request SHALL NOT be accepted in the same cycle the previous response is taken.
REQ-032 Outside RUN, the ALU outputs SHALL be: alu_cmd 111, alu_inA 0, alu_inB 0, alu_sc_i 0, alu_typeselect 00.
REQ-033 req_a, req_b, req_op and req_ci SHALL be ignored outside the accept cycle.

Reset
REQ-034 While reset_n=0, the FSM SHALL be in IDLE, req_ready 1, rsp_valid 0, rsp_data 0, rsp_co 0, rsp_zero 0 and the counter 0.
REQ-035 Reset asserted in RUN or DONE SHALL discard the operation with no response issued.

Configuration
REQ-036 With ALU_SEQ_ZFLAG_EN defined, rsp_zero SHALL be 1 when rsp_data is all zeros, registered with the result.
REQ-037 Without ALU_SEQ_ZFLAG_EN, rsp_zero SHALL be tied to 0, and the port SHALL remain present.

Structure
REQ-038 Package alu_seq_pkg SHALL hold the req_op enum, the ALU command constants (XOR 011, AND 101, SHIFT 001, PASS 111), the typeselect constants (SHL_C 11, SHR_C 01) and the FSM state enum.
REQ-039 The block SHALL be a single module with no sub-module; the ALU SHALL be instantiated alongside it at the level above.

Verification
REQ-040 XOR: A=0x12345678, B=0xFFFF0000 -> rsp_data=0xEDCB5678, rsp_co=0, rsp_valid on cycle 5 after accept.
REQ-041 SHL: A=0x80000001, ci=1 -> rsp_data=0x00000003, rsp_co=1.
REQ-042 SHR: A=0x00000003, ci=1 -> rsp_data=0x80000001, rsp_co=1; the bench SHALL check alu_inA byte order 00,00,00,03.
REQ-043 AND: A=0xF0F0F0F0, B=0x0F0F0F0F -> rsp_data=0, rsp_zero=1 with the macro and 0 without it.
REQ-044 Backpressure: rsp_ready held 0 for 10 cycles with req_valid held 1 -> rsp stable, req_ready 0 throughout, second op accepted one cycle after the handshake.
REQ-045 reset_n pulsed low in the 2nd RUN cycle -> IDLE, rsp_valid never asserted, the next op correct.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the byte-serial ALU sequencer.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    OpXor = 2'b00,
    OpAnd = 2'b01,
    OpShl = 2'b10,
    OpShr = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam logic [2:0] AluCmdXor   = 3'b011;
  localparam logic [2:0] AluCmdAnd   = 3'b101;
  localparam logic [2:0] AluCmdShift = 3'b001;
  localparam logic [2:0] AluCmdPass  = 3'b111;

  localparam logic [1:0] TypeShlC = 2'b11;
  localparam logic [1:0] TypeShrC = 2'b01;
  localparam logic [1:0] TypeNone = 2'b00;

  // Byte counter width; covers NBYTES up to 8.
  localparam int unsigned CntW = 3;

  function automatic logic is_shift(op_e op);
    return (op == OpShl) || (op == OpShr);
  endfunction

endpackage

// File: rtl/alu_seq.sv
// Byte-serial sequencer driving an external 8-bit combinational ALU.
// Optional zero flag enabled by defining ALU_SEQ_ZFLAG_EN.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [8*NBYTES-1:0]   req_a,
  input  logic [8*NBYTES-1:0]   req_b,
  input  logic                  req_ci,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [8*NBYTES-1:0]   rsp_data,
  output logic                  rsp_co,
  output logic                  rsp_zero,
  output logic [2:0]            alu_cmd,
  output logic [7:0]            alu_inA,
  output logic [7:0]            alu_inB,
  output logic                  alu_sc_i,
  output logic [1:0]            alu_typeselect,
  output logic [3:0]            alu_immed,
  input  logic [7:0]            alu_rslt,
  input  logic                  alu_sc_o
);

  localparam int unsigned W = 8 * NBYTES;

  state_e          r_state, w_state_nxt;
  logic [CntW-1:0] r_cnt, w_k;
  logic [W-1:0]    r_a, r_b, r_res, w_res_nxt;
  op_e             r_op;
  logic            r_carry, r_co;
  logic            w_accept, w_last;
  logic [7:0]      w_byte_a, w_byte_b;

  assign w_accept = req_valid && (r_state == StIdle);
  assign w_last   = (r_cnt == CntW'(NBYTES - 1));
  // SHR walks the operand MSB first so the carry ripples downward.
  assign w_k      = (r_op == OpShr) ? (CntW'(NBYTES - 1) - r_cnt) : r_cnt;

  always_comb begin
    w_byte_a  = '0;
    w_byte_b  = '0;
    w_res_nxt = r_res;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (w_k == CntW'(i)) begin
        w_byte_a              = r_a[8*i +: 8];
        w_byte_b              = r_b[8*i +: 8];
        w_res_nxt[8*i +: 8]   = alu_rslt;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    req_ready      = 1'b0;
    alu_cmd        = AluCmdPass;
    alu_inA        = '0;
    alu_inB        = '0;
    alu_sc_i       = 1'b0;
    alu_typeselect = TypeNone;
    unique case (r_state)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nxt = StRun;
      end
      StRun: begin
        alu_inA  = w_byte_a;
        alu_inB  = w_byte_b;
        alu_sc_i = r_carry;
        unique case (r_op)
          OpXor: alu_cmd = AluCmdXor;
          OpAnd: alu_cmd = AluCmdAnd;
          OpShl: begin
            alu_cmd        = AluCmdShift;
            alu_typeselect = TypeShlC;
          end
          OpShr: begin
            alu_cmd        = AluCmdShift;
            alu_typeselect = TypeShrC;
          end
          default: alu_cmd = AluCmdPass;
        endcase
        if (w_last) w_state_nxt = StDone;
      end
      StDone: begin
        if (rsp_ready) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= OpXor;
      r_carry <= 1'b0;
      r_res   <= '0;
      r_co    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_a     <= req_a;
        r_b     <= req_b;
        r_op    <= op_e'(req_op);
        r_carry <= req_ci;
        r_cnt   <= '0;
      end else if (r_state == StRun) begin
        r_cnt   <= r_cnt + CntW'(1);
        r_carry <= alu_sc_o;
        r_res   <= w_res_nxt;
        if (w_last) r_co <= is_shift(r_op) ? alu_sc_o : 1'b0;
      end
    end
  end

`ifdef ALU_SEQ_ZFLAG_EN
  logic r_zero;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_zero <= 1'b0;
    end else if ((r_state == StRun) && w_last) begin
      r_zero <= (w_res_nxt == '0);
    end
  end

  assign rsp_zero = r_zero;
`else
  assign rsp_zero = 1'b0;
`endif

  assign rsp_valid = (r_state == StDone);
  assign rsp_data  = r_res;
  assign rsp_co    = r_co;
  assign alu_immed = 4'b0000;

endmodule
